nanomamba_seq_ctrl: RTL and testbench
=====================================

Name: nanomamba_seq_ctrl

Overview:
Inference sequencer for the NanoMamba accelerator. It takes the one-cycle start, stop and reset pulses from the register file and runs one inference in this order: the DualPCEN frontend, then cfg_n_layers SA-SSM layers, then the classifier. While the classifier streams out its logits, the block computes a running argmax and confidence. It drives busy/done/error status and the per-class logit writes back into the register file.

Parameters:
N_CLASSES, 12, number of classifier logits expected per inference
LAYER_W, 4, width of the layer count and layer index
CLS_W, 4, width of the class index; must satisfy 2^CLS_W >= N_CLASSES
WDOG_W, 20, watchdog counter width; timeout occurs after 2^WDOG_W-1 idle cycles in a stage

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ctrl_start  in  1  one-cycle start pulse from the register file
ctrl_stop  in  1  one-cycle abort pulse
ctrl_reset  in  1  one-cycle soft reset
cfg_n_layers  in  LAYER_W  number of SSM layers to run (0 is legal)
status_busy  out  1  an inference is in progress
status_done  out  1  the last inference completed cleanly (sticky)
status_error  out  1  the last inference failed (sticky)
fe_start  out  1  frontend start pulse
fe_done  in  1  frontend completion pulse
ssm_start  out  1  SSM layer start pulse
ssm_layer  out  LAYER_W  index of the layer currently running
ssm_done  in  1  SSM layer completion pulse
cls_start  out  1  classifier start pulse
cls_logit_valid  in  1  logit strobe
cls_logit  in  8  signed INT8 logit
cls_done  in  1  classifier completion pulse
logit_wr_en  out  1  logit write strobe to the register file
logit_idx  out  CLS_W  logit write index
logit_data  out  8  logit write data
result_class  out  CLS_W  argmax class index
result_confidence  out  8  maximum logit, raw INT8

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Priority of simultaneous events: rst_n, then ctrl_reset, then ctrl_stop, then watchdog timeout, then ctrl_start, then done/valid inputs.
- States: IDLE, FE, SSM, CLS, DONE, ERR. status_busy=1 exactly while in FE, SSM or CLS.
- ctrl_reset has the same effect as rst_n, including clearing the results.
- ctrl_start in IDLE, DONE or ERR (cycle t):
  - latch cfg_n_layers; clear done, error, logit count and argmax.
  - enter FE at t+1, with fe_start=1 for the single cycle t+1.
  - ctrl_start while busy is ignored.
- FE: on fe_done, go to SSM if the latched n_layers>0, otherwise go to CLS.
- SSM:
  - entry sets ssm_layer=0 and pulses ssm_start in the entry cycle.
  - on ssm_done with ssm_layer < n_layers-1: increment ssm_layer and pulse ssm_start on the next cycle.
  - on ssm_done with ssm_layer = n_layers-1: go to CLS.
- CLS:
  - cls_start pulses in the entry cycle.
  - each cls_logit_valid produces, one cycle later, logit_wr_en=1, logit_idx=count, logit_data=cls_logit; count then increments.
  - argmax uses signed comparison. An update happens only on strictly greater, so ties keep the lowest index. The first logit always initialises the argmax.
  - valid strobes beyond N_CLASSES are not written and set an overflow flag.
- CLS completion on cls_done (a cls_logit_valid in the same cycle is counted first):
  - if count==N_CLASSES and no overflow: go to DONE, result_class/result_confidence update, status_done=1.
  - otherwise: go to ERR, status_error=1, results unchanged.
- Only the done input of the current stage is honoured. Stray fe_done/ssm_done/cls_done/cls_logit_valid in any other state are ignored.
- Watchdog: cleared on stage entry and on any accepted done or valid; increments while busy. On reaching all-ones, go to ERR with status_error=1.
- ctrl_stop while busy: go to IDLE next cycle; busy, done and error all 0; results hold; no further start pulses. ctrl_stop while idle has no effect.
- Start pulses never overlap; at most one of fe_start/ssm_start/cls_start is high per cycle.
- Result outputs change only on the DONE entry.

Decomposition:
- Shared package nanomamba_pkg: seq_state_t enum, N_CLASSES, LOGIT_W=8, CLS_W, LAYER_W.
- One sub-module, nanomamba_argmax: streaming signed max/index tracker with clear and valid inputs, returning max_val and max_idx.

Test Plan:
- Nominal run: n_layers=2, logits {-5,3,7,7,-128,0,1,2,6,-1,4,5} → fe_start once, ssm_start with ssm_layer 0 then 1, cls_start once, 12 logit writes with idx 0..11, result_class=2, result_confidence=7, done=1, busy=0.
- n_layers=0 → fe_done leads directly to cls_start, with no ssm_start issued.
- Logit count mismatch: 11 logits then cls_done → status_error=1, results hold their previous values. 13 logits → 12 writes, then error.
- Watchdog: fe_done withheld with WDOG_W=4 → ERR after 15 cycles; a following ctrl_start reruns cleanly.
- Abort: ctrl_stop during SSM layer 1, followed by a late ssm_done → IDLE, busy=0, and no further start pulses.
- Simultaneous events: ctrl_start together with ctrl_reset → reset wins and the state stays IDLE. ctrl_start while busy is ignored. rst_n low mid-CLS → all outputs 0 on the next edge.

Source files
------------

// File: rtl/nanomamba_pkg.sv
// Shared types and default sizing for the NanoMamba inference sequencer.
// The sequencer top and the argmax tracker both import this package.
package nanomamba_pkg;

    localparam int N_CLASSES = 12;
    localparam int LOGIT_W   = 8;
    localparam int CLS_W     = 4;
    localparam int LAYER_W   = 4;
    localparam int WDOG_W    = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FE,
        S_SSM,
        S_CLS,
        S_DONE,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/nanomamba_argmax.sv
// Streaming signed argmax tracker. The outputs already include the sample presented
// this cycle, so a caller can commit the final result in the same cycle as the last logit.
module nanomamba_argmax
    import nanomamba_pkg::*;
#(
    parameter int IDX_W = nanomamba_pkg::CLS_W,
    parameter int VAL_W = nanomamba_pkg::LOGIT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic signed [VAL_W-1:0] i_val,
    input  logic        [IDX_W-1:0] i_idx,
    output logic signed [VAL_W-1:0] o_max_val,
    output logic        [IDX_W-1:0] o_max_idx
);

    logic                    r_have;
    logic signed [VAL_W-1:0] r_max_val;
    logic        [IDX_W-1:0] r_max_idx;
    logic                    w_take;

    // Strictly-greater update keeps the lowest index on ties; the first sample always wins.
    assign w_take    = i_valid && (!r_have || (i_val > r_max_val));
    assign o_max_val = w_take ? i_val : r_max_val;
    assign o_max_idx = w_take ? i_idx : r_max_idx;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_have    <= 1'b0;
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (i_valid) begin
            r_have <= 1'b1;
            if (w_take) begin
                r_max_val <= i_val;
                r_max_idx <= i_idx;
            end
        end
    end

endmodule

// File: rtl/nanomamba_seq_ctrl.sv
// NanoMamba inference sequencer: frontend, then N SSM layers, then the classifier,
// with logit write-back, running argmax, stage watchdog and abort/soft-reset handling.
module nanomamba_seq_ctrl
    import nanomamba_pkg::*;
#(
    parameter int N_CLASSES = nanomamba_pkg::N_CLASSES,
    parameter int LAYER_W   = nanomamba_pkg::LAYER_W,
    parameter int CLS_W     = nanomamba_pkg::CLS_W,
    parameter int WDOG_W    = nanomamba_pkg::WDOG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ctrl_start,
    input  logic                      ctrl_stop,
    input  logic                      ctrl_reset,
    input  logic [LAYER_W-1:0]        cfg_n_layers,
    output logic                      status_busy,
    output logic                      status_done,
    output logic                      status_error,
    output logic                      fe_start,
    input  logic                      fe_done,
    output logic                      ssm_start,
    output logic [LAYER_W-1:0]        ssm_layer,
    input  logic                      ssm_done,
    output logic                      cls_start,
    input  logic                      cls_logit_valid,
    input  logic signed [LOGIT_W-1:0] cls_logit,
    input  logic                      cls_done,
    output logic                      logit_wr_en,
    output logic [CLS_W-1:0]          logit_idx,
    output logic [LOGIT_W-1:0]        logit_data,
    output logic [CLS_W-1:0]          result_class,
    output logic [LOGIT_W-1:0]        result_confidence
);

    // One spare bit so the count can represent N_CLASSES even when it equals 2^CLS_W.
    localparam int                CNT_W     = CLS_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_CLASSES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = ~(WDOG_W'(1));

    seq_state_t                r_state;
    seq_state_t                w_next;
    logic [LAYER_W-1:0]        r_n_layers;
    logic [LAYER_W-1:0]        r_layer;
    logic [CNT_W-1:0]          r_count;
    logic                      r_ovf;
    logic [WDOG_W-1:0]         r_wdog;
    logic                      r_fe_start;
    logic                      r_ssm_start;
    logic                      r_cls_start;
    logic                      r_wr_en;
    logic [CLS_W-1:0]          r_wr_idx;
    logic [LOGIT_W-1:0]        r_wr_data;
    logic [CLS_W-1:0]          r_res_class;
    logic [LOGIT_W-1:0]        r_res_conf;

    logic                      w_busy;
    logic                      w_timeout;
    logic                      w_start_acc;
    logic                      w_kick;
    logic                      w_log_acc;
    logic                      w_ovf_hit;
    logic                      w_ssm_adv;
    logic                      w_last_layer;
    logic                      w_argmax_clr;
    logic signed [LOGIT_W-1:0] w_max_val;
    logic [CLS_W-1:0]          w_max_idx;

    assign w_busy       = (r_state == S_FE) || (r_state == S_SSM) || (r_state == S_CLS);
    assign w_timeout    = w_busy && (r_wdog == WDOG_LAST);
    assign w_last_layer = (r_layer == (r_n_layers - 1'b1));
    assign w_argmax_clr = ctrl_reset || w_start_acc;

    always_ff @(posedge clk) begin
        if (!rst_n || ctrl_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Event priority: soft reset, stop, watchdog, then start / stage inputs of the current state only.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_kick      = 1'b0;
        w_log_acc   = 1'b0;
        w_ovf_hit   = 1'b0;
        w_ssm_adv   = 1'b0;
        if (ctrl_reset) begin
            w_next = S_IDLE;
        end else if (ctrl_stop && w_busy) begin
            w_next = S_IDLE;
        end else if (w_timeout) begin
            w_next = S_ERR;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (ctrl_start) begin
                        w_start_acc = 1'b1;
                        w_next      = S_FE;
                    end
                end
                S_FE: begin
                    if (fe_done) begin
                        w_kick = 1'b1;
                        w_next = (r_n_layers != '0) ? S_SSM : S_CLS;
                    end
                end
                S_SSM: begin
                    if (ssm_done) begin
                        w_kick = 1'b1;
                        if (w_last_layer) begin
                            w_next = S_CLS;
                        end else begin
                            w_ssm_adv = 1'b1;
                        end
                    end
                end
                S_CLS: begin
                    if (cls_logit_valid) begin
                        w_kick = 1'b1;
                        if (r_count < CNT_FULL) begin
                            w_log_acc = 1'b1;
                        end else begin
                            w_ovf_hit = 1'b1;
                        end
                    end
                    if (cls_done) begin
                        w_kick = 1'b1;
                        if (((r_count + CNT_W'(w_log_acc)) == CNT_FULL) && !(r_ovf || w_ovf_hit)) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_ERR;
                        end
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ctrl_reset) begin
            r_n_layers  <= '0;
            r_layer     <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_wdog      <= '0;
            r_fe_start  <= 1'b0;
            r_ssm_start <= 1'b0;
            r_cls_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_data   <= '0;
            r_res_class <= '0;
            r_res_conf  <= '0;
        end else begin
            r_fe_start  <= (w_next == S_FE) && (r_state != S_FE);
            r_ssm_start <= ((w_next == S_SSM) && (r_state != S_SSM)) || w_ssm_adv;
            r_cls_start <= (w_next == S_CLS) && (r_state != S_CLS);
            r_wr_en     <= w_log_acc;
            // Counts only idle cycles within one stage; any progress or stage change restarts it.
            r_wdog      <= (w_busy && !w_kick && (w_next == r_state)) ? r_wdog + 1'b1 : '0;
            if (w_start_acc) begin
                r_n_layers <= cfg_n_layers;
                r_count    <= '0;
                r_ovf      <= 1'b0;
            end
            if ((w_next == S_SSM) && (r_state != S_SSM)) begin
                r_layer <= '0;
            end else if (w_ssm_adv) begin
                r_layer <= r_layer + 1'b1;
            end
            if (w_log_acc) begin
                r_wr_idx  <= r_count[CLS_W-1:0];
                r_wr_data <= cls_logit;
                r_count   <= r_count + 1'b1;
            end
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
            if ((w_next == S_DONE) && (r_state == S_CLS)) begin
                r_res_class <= w_max_idx;
                r_res_conf  <= w_max_val;
            end
        end
    end

    nanomamba_argmax #(
        .IDX_W (CLS_W),
        .VAL_W (LOGIT_W)
    ) u_argmax (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_argmax_clr),
        .i_valid   (w_log_acc),
        .i_val     (cls_logit),
        .i_idx     (r_count[CLS_W-1:0]),
        .o_max_val (w_max_val),
        .o_max_idx (w_max_idx)
    );

    assign status_busy       = w_busy;
    assign status_done       = (r_state == S_DONE);
    assign status_error      = (r_state == S_ERR);
    assign fe_start          = r_fe_start;
    assign ssm_start         = r_ssm_start;
    assign ssm_layer         = r_layer;
    assign cls_start         = r_cls_start;
    assign logit_wr_en       = r_wr_en;
    assign logit_idx         = r_wr_idx;
    assign logit_data        = r_wr_data;
    assign result_class      = r_res_class;
    assign result_confidence = r_res_conf;

endmodule

// File: tb/tb_nanomamba_seq_ctrl.sv
// Randomized self-checking bench for nanomamba_seq_ctrl; expected results come from
// a plain argmax over the logit table and the stage ordering rules.
module tb_nanomamba_seq_ctrl;

    localparam int NCLS = 12;
    localparam int LW   = 4;
    localparam int CW   = 4;
    localparam int WW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctrl_start, ctrl_stop, ctrl_reset;
    logic [LW-1:0] cfg_n_layers;
    logic          status_busy, status_done, status_error;
    logic          fe_start, fe_done, ssm_start, ssm_done, cls_start;
    logic [LW-1:0] ssm_layer;
    logic          cls_logit_valid, cls_done;
    logic [7:0]    cls_logit;
    logic          logit_wr_en;
    logic [CW-1:0] logit_idx, result_class;
    logic [7:0]    logit_data, result_confidence;

    always #5 clk = ~clk;

    nanomamba_seq_ctrl #(
        .N_CLASSES (NCLS),
        .LAYER_W   (LW),
        .CLS_W     (CW),
        .WDOG_W    (WW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ctrl_start        (ctrl_start),
        .ctrl_stop         (ctrl_stop),
        .ctrl_reset        (ctrl_reset),
        .cfg_n_layers      (cfg_n_layers),
        .status_busy       (status_busy),
        .status_done       (status_done),
        .status_error      (status_error),
        .fe_start          (fe_start),
        .fe_done           (fe_done),
        .ssm_start         (ssm_start),
        .ssm_layer         (ssm_layer),
        .ssm_done          (ssm_done),
        .cls_start         (cls_start),
        .cls_logit_valid   (cls_logit_valid),
        .cls_logit         (cls_logit),
        .cls_done          (cls_done),
        .logit_wr_en       (logit_wr_en),
        .logit_idx         (logit_idx),
        .logit_data        (logit_data),
        .result_class      (result_class),
        .result_confidence (result_confidence)
    );

    int         checkCount = 0;
    int         passCount  = 0;
    int         feSeen, clsSeen, overlapSeen;
    int         ssmLayerQ[$];
    int         wrIdxQ[$];
    int         wrDataQ[$];
    logic [7:0] logitArr[16];
    int         modelClass, modelConf;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Passive monitor: records every start pulse and logit write between the clock edges.
    always @(negedge clk) begin
        if (fe_start) feSeen++;
        if (ssm_start) ssmLayerQ.push_back(int'(ssm_layer));
        if (cls_start) clsSeen++;
        if (int'(fe_start) + int'(ssm_start) + int'(cls_start) > 1) overlapSeen++;
        if (logit_wr_en) begin
            wrIdxQ.push_back(int'(logit_idx));
            wrDataQ.push_back(int'(logit_data));
        end
    end

    task automatic clearMonitor();
        feSeen = 0;
        clsSeen = 0;
        overlapSeen = 0;
        ssmLayerQ.delete();
        wrIdxQ.delete();
        wrDataQ.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic delayRand(input int maxCycles);
        repeat ($urandom_range(0, maxCycles)) tick();
    endtask

    function automatic logic startSel(input int which);
        case (which)
            0:       return fe_start;
            1:       return ssm_start;
            default: return cls_start;
        endcase
    endfunction

    task automatic waitPulse(input int which, input string tag);
        int n = 0;
        while (!startSel(which) && n < 30) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(startSel(which)), 64'd1);
    endtask

    task automatic fillLogits();
        bit narrow = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) begin
            logitArr[i] = narrow ? 8'(int'($urandom_range(0, 6)) - 3) : 8'($urandom);
        end
    endtask

    // Plays frontend, SSM and classifier for one inference with randomized handshake timing.
    task automatic applyStimulus(input int nLayers, input int nLogits, input bit coincide, input bit pokeStart);
        clearMonitor();
        cfg_n_layers = LW'(nLayers);
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        cfg_n_layers = LW'($urandom_range(0, 15));
        waitPulse(0, "fe_start");
        delayRand(3);
        if (pokeStart) begin
            ctrl_start = 1'b1;
            tick();
            ctrl_start = 1'b0;
        end
        fe_done = 1'b1;
        tick();
        fe_done = 1'b0;
        for (int l = 0; l < nLayers; l++) begin
            waitPulse(1, "ssm_start");
            delayRand(3);
            ssm_done = 1'b1;
            tick();
            ssm_done = 1'b0;
        end
        waitPulse(2, "cls_start");
        for (int i = 0; i < nLogits; i++) begin
            delayRand(2);
            cls_logit = logitArr[i];
            cls_logit_valid = 1'b1;
            if (coincide && i == nLogits - 1) cls_done = 1'b1;
            tick();
            cls_logit_valid = 1'b0;
            cls_done = 1'b0;
        end
        if (!coincide || nLogits == 0) begin
            delayRand(2);
            cls_done = 1'b1;
            tick();
            cls_done = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic verifyInference(input int nLayers, input int nLogits);
        bit ok = (nLogits == NCLS);
        int expWrites = (nLogits < NCLS) ? nLogits : NCLS;
        int mism = 0;
        int best = 0;
        if (ok) begin
            for (int i = 1; i < NCLS; i++) begin
                if ($signed(logitArr[i]) > $signed(logitArr[best])) best = i;
            end
            modelClass = best;
            modelConf = int'(logitArr[best]);
        end
        checkOutput("busy", 64'(status_busy), 64'd0);
        checkOutput("done", 64'(status_done), 64'(ok));
        checkOutput("error", 64'(status_error), 64'(!ok));
        checkOutput("result_class", 64'(result_class), 64'(modelClass));
        checkOutput("result_conf", 64'(result_confidence), 64'(modelConf));
        checkOutput("fe_start_count", 64'(feSeen), 64'd1);
        checkOutput("cls_start_count", 64'(clsSeen), 64'd1);
        checkOutput("ssm_start_count", 64'(ssmLayerQ.size()), 64'(nLayers));
        for (int i = 0; i < ssmLayerQ.size(); i++) begin
            if (ssmLayerQ[i] != i) mism++;
        end
        checkOutput("ssm_layer_seq", 64'(mism), 64'd0);
        checkOutput("write_count", 64'(wrIdxQ.size()), 64'(expWrites));
        mism = 0;
        for (int i = 0; i < wrIdxQ.size(); i++) begin
            if (wrIdxQ[i] != i || wrDataQ[i] != int'(logitArr[i])) mism++;
        end
        checkOutput("write_content", 64'(mism), 64'd0);
        checkOutput("start_overlap", 64'(overlapSeen), 64'd0);
    endtask

    initial begin
        int nL, nLog, cycles, pick;
        rst_n = 1'b0;
        ctrl_start = 1'b0;
        ctrl_stop = 1'b0;
        ctrl_reset = 1'b0;
        cfg_n_layers = '0;
        fe_done = 1'b0;
        ssm_done = 1'b0;
        cls_logit_valid = 1'b0;
        cls_logit = '0;
        cls_done = 1'b0;
        modelClass = 0;
        modelConf = 0;
        clearMonitor();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("reset_outputs", {status_busy, status_done, status_error, fe_start, ssm_start, ssm_layer,
                    cls_start, logit_wr_en, logit_idx, logit_data, result_class, result_confidence}, 64'd0);

        // Nominal run from the worked example, with a start poke while busy.
        logitArr = '{8'hFB, 8'd3, 8'd7, 8'd7, 8'h80, 8'd0, 8'd1, 8'd2, 8'd6, 8'hFF, 8'd4, 8'd5,
                     8'd0, 8'd0, 8'd0, 8'd0};
        applyStimulus(2, 12, 1'b0, 1'b1);
        verifyInference(2, 12);
        checkOutput("nominal_class", 64'(result_class), 64'd2);
        checkOutput("nominal_conf", 64'(result_confidence), 64'd7);

        fillLogits();
        applyStimulus(0, 12, 1'b1, 1'b0);
        verifyInference(0, 12);
        fillLogits();
        applyStimulus(1, 11, 1'b0, 1'b0);
        verifyInference(1, 11);
        fillLogits();
        applyStimulus(1, 13, 1'b1, 1'b0);
        verifyInference(1, 13);

        for (int it = 0; it < 8; it++) begin
            fillLogits();
            nL = $urandom_range(0, 3);
            pick = $urandom_range(0, 5);
            nLog = (pick == 0) ? 11 : (pick == 1) ? 13 : 12;
            applyStimulus(nL, nLog, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            verifyInference(nL, nLog);
        end

        // Watchdog: the frontend never answers.
        clearMonitor();
        cfg_n_layers = 4'd1;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        cycles = 0;
        while (status_busy && cycles < 40) begin
            cycles++;
            tick();
        end
        checkOutput("wdog_cycles", 64'(cycles), 64'd15);
        checkOutput("wdog_error", 64'(status_error), 64'd1);
        checkOutput("wdog_class_hold", 64'(result_class), 64'(modelClass));
        fillLogits();
        applyStimulus(1, 12, 1'b0, 1'b0);
        verifyInference(1, 12);

        // Abort during SSM layer 1, then a late ssm_done.
        clearMonitor();
        cfg_n_layers = 4'd3;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        waitPulse(0, "abort_fe_start");
        fe_done = 1'b1;
        tick();
        fe_done = 1'b0;
        waitPulse(1, "abort_ssm0");
        ssm_done = 1'b1;
        tick();
        ssm_done = 1'b0;
        waitPulse(1, "abort_ssm1");
        checkOutput("abort_layer", 64'(ssm_layer), 64'd1);
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        checkOutput("abort_status", {status_busy, status_done, status_error}, 64'd0);
        checkOutput("abort_conf_hold", 64'(result_confidence), 64'(modelConf));
        clearMonitor();
        tick();
        ssm_done = 1'b1;
        tick();
        ssm_done = 1'b0;
        repeat (5) tick();
        checkOutput("abort_no_starts", 64'(feSeen + ssmLayerQ.size() + clsSeen), 64'd0);
        checkOutput("abort_idle", 64'(status_busy), 64'd0);

        // Start and soft reset together after a clean run: reset wins.
        fillLogits();
        applyStimulus(0, 12, 1'b0, 1'b0);
        verifyInference(0, 12);
        ctrl_start = 1'b1;
        ctrl_reset = 1'b1;
        cfg_n_layers = 4'd2;
        tick();
        ctrl_start = 1'b0;
        ctrl_reset = 1'b0;
        clearMonitor();
        modelClass = 0;
        modelConf = 0;
        checkOutput("softreset_status", {status_busy, status_done, status_error}, 64'd0);
        checkOutput("softreset_results", {result_class, result_confidence}, 64'd0);
        repeat (3) tick();
        checkOutput("softreset_no_fe", 64'(feSeen), 64'd0);

        // rst_n asserted in the middle of classification.
        fillLogits();
        cfg_n_layers = 4'd0;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        fe_done = 1'b1;
        tick();
        fe_done = 1'b0;
        waitPulse(2, "midcls_cls_start");
        for (int i = 0; i < 3; i++) begin
            cls_logit = logitArr[i];
            cls_logit_valid = 1'b1;
            tick();
            cls_logit_valid = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        checkOutput("midcls_reset", {status_busy, status_done, status_error, fe_start, ssm_start, ssm_layer,
                    cls_start, logit_wr_en, logit_idx, logit_data, result_class, result_confidence}, 64'd0);
        rst_n = 1'b1;
        tick();
        fillLogits();
        applyStimulus(2, 12, 1'b1, 1'b0);
        verifyInference(2, 12);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
